sc_sidedetect: RTL and testbench



---
 rtl/sc_game_pkg.sv | 17 +
 rtl/sc_onehot_encoder.sv | 26 ++
 rtl/sc_sidedetect.sv | 177 +++++++++++++++++
 tb/tb_sc_sidedetect.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_game_pkg.sv
// Shared definitions for the two-player game datapath.
// Holds the direction encodings driven on the side detector's dir bus and the
// direction FSM state type, whose encodings equal the dir codes so the state
// register can drive the output directly.
package sc_game_pkg;

  localparam logic [1:0] DIR_IDLE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;  // index decreasing
  localparam logic [1:0] DIR_LEFT  = 2'b10;  // index increasing

  typedef enum logic [1:0] {
    StIdle  = DIR_IDLE,
    StRight = DIR_RIGHT,
    StLeft  = DIR_LEFT
  } dir_state_e;

endpackage

// File: rtl/sc_onehot_encoder.sv
// One-hot to binary index encoder.
// Ports:
//   data_i  - position bus, expected one-hot
//   idx_o   - index of the set bit (only meaningful when valid_o = 1)
//   valid_o - 1 when exactly one bit of data_i is set
module sc_onehot_encoder #(
  parameter int unsigned DATAWIDTH = 8,
  localparam int unsigned IdxWidth = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1
) (
  input  logic [DATAWIDTH-1:0] data_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 valid_o
);

  always_comb begin
    idx_o = '0;
    // OR of the indices of all set bits; exact only for a one-hot input.
    for (int i = 0; i < int'(DATAWIDTH); i++) begin
      if (data_i[i]) begin
        idx_o = idx_o | IdxWidth'(i);
      end
    end
    valid_o = $onehot(data_i);
  end

endmodule

// File: rtl/sc_sidedetect.sv
// Registered side detector for a shifting one-hot position bus.
// Reports arrival at the left/right boundary as active-low levels and
// one-cycle active-low entry pulses, tracks the direction of motion and
// counts bounces off the boundaries with a saturating counter.
// Ports:
//   SC_SIDEDETECT_CLOCK_50         - clock, rising edge
//   SC_SIDEDETECT_RESET_InLow      - synchronous active-low reset
//   SC_SIDEDETECT_enable_In        - sample strobe
//   SC_SIDEDETECT_clear_InLow      - synchronous active-low bounce counter clear
//   SC_SIDEDETECT_data_InBUS       - position bus
//   SC_SIDEDETECT_izquierda_OutLow - low while last sample was at LEFT_POS
//   SC_SIDEDETECT_derecha_OutLow   - low while last sample was at RIGHT_POS
//   SC_SIDEDETECT_izqPulse_OutLow  - one-cycle low on entry to LEFT_POS
//   SC_SIDEDETECT_derPulse_OutLow  - one-cycle low on entry to RIGHT_POS
//   SC_SIDEDETECT_dir_OutBUS       - 00 idle, 01 moving right, 10 moving left
//   SC_SIDEDETECT_bounce_OutBUS    - saturating bounce count
//   SC_SIDEDETECT_error_OutLow     - low for one cycle after a non-one-hot sample
module sc_sidedetect
  import sc_game_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned LEFT_POS  = 3,
  parameter int unsigned RIGHT_POS = 0,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 SC_SIDEDETECT_CLOCK_50,
  input  logic                 SC_SIDEDETECT_RESET_InLow,
  input  logic                 SC_SIDEDETECT_enable_In,
  input  logic                 SC_SIDEDETECT_clear_InLow,
  input  logic [DATAWIDTH-1:0] SC_SIDEDETECT_data_InBUS,
  output logic                 SC_SIDEDETECT_izquierda_OutLow,
  output logic                 SC_SIDEDETECT_derecha_OutLow,
  output logic                 SC_SIDEDETECT_izqPulse_OutLow,
  output logic                 SC_SIDEDETECT_derPulse_OutLow,
  output logic [1:0]           SC_SIDEDETECT_dir_OutBUS,
  output logic [CNT_WIDTH-1:0] SC_SIDEDETECT_bounce_OutBUS,
  output logic                 SC_SIDEDETECT_error_OutLow
);

  localparam int unsigned IdxWidth = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [IdxWidth-1:0] LeftIdx  = IdxWidth'(LEFT_POS);
  localparam logic [IdxWidth-1:0] RightIdx = IdxWidth'(RIGHT_POS);

  logic [IdxWidth-1:0] enc_idx;
  logic                enc_valid;

  sc_onehot_encoder #(
    .DATAWIDTH(DATAWIDTH)
  ) u_encoder (
    .data_i (SC_SIDEDETECT_data_InBUS),
    .idx_o  (enc_idx),
    .valid_o(enc_valid)
  );

  dir_state_e          state_q, state_d;
  logic [IdxWidth-1:0] prev_idx_q, prev_idx_d;
  logic                prev_valid_q, prev_valid_d;
  logic                izq_q, izq_d;
  logic                der_q, der_d;
  logic                izq_pulse_q, izq_pulse_d;
  logic                der_pulse_q, der_pulse_d;
  logic                err_q, err_d;
  logic [CNT_WIDTH-1:0] bounce_q, bounce_d;

  logic at_left, at_right, was_left, was_right, bump;

  always_comb begin
    at_left   = enc_valid && (enc_idx == LeftIdx);
    at_right  = enc_valid && (enc_idx == RightIdx);
    // An invalid previous sample never matches, so the first valid sample
    // after reset or an error counts as an entry.
    was_left  = prev_valid_q && (prev_idx_q == LeftIdx);
    was_right = prev_valid_q && (prev_idx_q == RightIdx);
  end

  // Next-state: direction FSM, outputs and counter.
  always_comb begin
    state_d      = state_q;
    prev_idx_d   = prev_idx_q;
    prev_valid_d = prev_valid_q;
    izq_d        = izq_q;
    der_d        = der_q;
    izq_pulse_d  = 1'b1;
    der_pulse_d  = 1'b1;
    err_d        = 1'b1;
    bump         = 1'b0;

    if (SC_SIDEDETECT_enable_In) begin
      if (!enc_valid) begin
        err_d        = 1'b0;
        izq_d        = 1'b1;
        der_d        = 1'b1;
        state_d      = StIdle;
        prev_valid_d = 1'b0;
      end else begin
        izq_d        = !at_left;
        der_d        = !at_right;
        izq_pulse_d  = !(at_left && !was_left);
        der_pulse_d  = !(at_right && !was_right);
        prev_idx_d   = enc_idx;
        prev_valid_d = 1'b1;

        unique case (state_q)
          StIdle: begin
            // Leaving idle never counts a bounce, even onto a boundary.
            if (prev_valid_q) begin
              if (enc_idx > prev_idx_q) begin
                state_d = StLeft;
              end else if (enc_idx < prev_idx_q) begin
                state_d = StRight;
              end
            end
          end
          StLeft: begin
            if (at_left) begin
              state_d = StRight;
              bump    = 1'b1;
            end else if (enc_idx < prev_idx_q) begin
              state_d = StRight;
            end
          end
          StRight: begin
            if (at_right) begin
              state_d = StLeft;
              bump    = 1'b1;
            end else if (enc_idx > prev_idx_q) begin
              state_d = StLeft;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // Clear wins over a simultaneous bounce; count saturates at all-ones.
    if (!SC_SIDEDETECT_clear_InLow) begin
      bounce_d = '0;
    end else if (bump && (bounce_q != {CNT_WIDTH{1'b1}})) begin
      bounce_d = bounce_q + CNT_WIDTH'(1);
    end else begin
      bounce_d = bounce_q;
    end
  end

  always_ff @(posedge SC_SIDEDETECT_CLOCK_50) begin
    if (!SC_SIDEDETECT_RESET_InLow) begin
      state_q      <= StIdle;
      prev_idx_q   <= '0;
      prev_valid_q <= 1'b0;
      izq_q        <= 1'b1;
      der_q        <= 1'b1;
      izq_pulse_q  <= 1'b1;
      der_pulse_q  <= 1'b1;
      err_q        <= 1'b1;
      bounce_q     <= '0;
    end else begin
      state_q      <= state_d;
      prev_idx_q   <= prev_idx_d;
      prev_valid_q <= prev_valid_d;
      izq_q        <= izq_d;
      der_q        <= der_d;
      izq_pulse_q  <= izq_pulse_d;
      der_pulse_q  <= der_pulse_d;
      err_q        <= err_d;
      bounce_q     <= bounce_d;
    end
  end

  assign SC_SIDEDETECT_izquierda_OutLow = izq_q;
  assign SC_SIDEDETECT_derecha_OutLow   = der_q;
  assign SC_SIDEDETECT_izqPulse_OutLow  = izq_pulse_q;
  assign SC_SIDEDETECT_derPulse_OutLow  = der_pulse_q;
  assign SC_SIDEDETECT_dir_OutBUS       = state_q;
  assign SC_SIDEDETECT_bounce_OutBUS    = bounce_q;
  assign SC_SIDEDETECT_error_OutLow     = err_q;

endmodule

// File: tb/tb_sc_sidedetect.sv
// Bench for sc_sidedetect: two instances (CNT_WIDTH 4 and 2) share stimulus.
// A behavioural model predicts every output each cycle; literal checks pin
// the model at the points of the directed sequence.
module tb_sc_sidedetect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr_n = 1'b1;
  logic [7:0] bus = 8'h00;

  logic       izq_a, der_a, izqp_a, derp_a, err_a;
  logic [1:0] dir_a;
  logic [3:0] cnt_a;
  logic       izq_b, der_b, izqp_b, derp_b, err_b;
  logic [1:0] dir_b;
  logic [1:0] cnt_b;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  sc_sidedetect #(
    .DATAWIDTH(8), .LEFT_POS(3), .RIGHT_POS(0), .CNT_WIDTH(4)
  ) dut_a (
    .SC_SIDEDETECT_CLOCK_50        (clk),
    .SC_SIDEDETECT_RESET_InLow     (rst_n),
    .SC_SIDEDETECT_enable_In       (en),
    .SC_SIDEDETECT_clear_InLow     (clr_n),
    .SC_SIDEDETECT_data_InBUS      (bus),
    .SC_SIDEDETECT_izquierda_OutLow(izq_a),
    .SC_SIDEDETECT_derecha_OutLow  (der_a),
    .SC_SIDEDETECT_izqPulse_OutLow (izqp_a),
    .SC_SIDEDETECT_derPulse_OutLow (derp_a),
    .SC_SIDEDETECT_dir_OutBUS      (dir_a),
    .SC_SIDEDETECT_bounce_OutBUS   (cnt_a),
    .SC_SIDEDETECT_error_OutLow    (err_a)
  );

  sc_sidedetect #(
    .DATAWIDTH(8), .LEFT_POS(3), .RIGHT_POS(0), .CNT_WIDTH(2)
  ) dut_b (
    .SC_SIDEDETECT_CLOCK_50        (clk),
    .SC_SIDEDETECT_RESET_InLow     (rst_n),
    .SC_SIDEDETECT_enable_In       (en),
    .SC_SIDEDETECT_clear_InLow     (clr_n),
    .SC_SIDEDETECT_data_InBUS      (bus),
    .SC_SIDEDETECT_izquierda_OutLow(izq_b),
    .SC_SIDEDETECT_derecha_OutLow  (der_b),
    .SC_SIDEDETECT_izqPulse_OutLow (izqp_b),
    .SC_SIDEDETECT_derPulse_OutLow (derp_b),
    .SC_SIDEDETECT_dir_OutBUS      (dir_b),
    .SC_SIDEDETECT_bounce_OutBUS   (cnt_b),
    .SC_SIDEDETECT_error_OutLow    (err_b)
  );

  // Model: prev = -1 when no valid previous sample; dir 0 idle, 1 right, 2 left.
  typedef struct {
    int prev;
    int dir;
    int cnt_a;
    int cnt_b;
    bit izq, der, izqp, derp, err;
  } model_t;

  model_t m = '{prev: -1, dir: 0, cnt_a: 0, cnt_b: 0,
                izq: 1, der: 1, izqp: 1, derp: 1, err: 1};

  function automatic model_t next_model(model_t cur, bit r, bit e, bit c, logic [7:0] b);
    model_t n = cur;
    int idx = 0;
    bit bump = 0;
    n.izqp = 1; n.derp = 1; n.err = 1;
    if (!r) begin
      n.prev = -1; n.dir = 0; n.cnt_a = 0; n.cnt_b = 0; n.izq = 1; n.der = 1;
      return n;
    end
    if (e) begin
      if ($countones(b) != 1) begin
        n.err = 0; n.izq = 1; n.der = 1; n.dir = 0; n.prev = -1;
      end else begin
        for (int i = 0; i < 8; i++) if (b[i]) idx = i;
        n.izq  = (idx != 3);
        n.der  = (idx != 0);
        n.izqp = !(idx == 3 && cur.prev != 3);
        n.derp = !(idx == 0 && cur.prev != 0);
        if (cur.dir == 0) begin
          if (cur.prev >= 0 && idx > cur.prev) n.dir = 2;
          else if (cur.prev >= 0 && idx < cur.prev) n.dir = 1;
        end else if (cur.dir == 2) begin
          if (idx == 3) begin n.dir = 1; bump = 1; end
          else if (idx < cur.prev) n.dir = 1;
        end else begin
          if (idx == 0) begin n.dir = 2; bump = 1; end
          else if (idx > cur.prev) n.dir = 2;
        end
        n.prev = idx;
      end
    end
    if (bump) begin
      n.cnt_a = (cur.cnt_a + 1 > 15) ? 15 : cur.cnt_a + 1;
      n.cnt_b = (cur.cnt_b + 1 > 3) ? 3 : cur.cnt_b + 1;
    end
    if (!c) begin
      n.cnt_a = 0; n.cnt_b = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= next_model(m, rst_n, en, clr_n, bus);
    check_en <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkx(input string name, input logic [3:0] act, input int exp);
    total++;
    if ($isunknown(act) || int'(act) != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chkx("a.izq", {3'b0, izq_a}, int'(m.izq));
      chkx("a.der", {3'b0, der_a}, int'(m.der));
      chkx("a.izqp", {3'b0, izqp_a}, int'(m.izqp));
      chkx("a.derp", {3'b0, derp_a}, int'(m.derp));
      chkx("a.err", {3'b0, err_a}, int'(m.err));
      chkx("a.dir", {2'b0, dir_a}, m.dir);
      chkx("a.cnt", cnt_a, m.cnt_a);
      chkx("b.izq", {3'b0, izq_b}, int'(m.izq));
      chkx("b.der", {3'b0, der_b}, int'(m.der));
      chkx("b.izqp", {3'b0, izqp_b}, int'(m.izqp));
      chkx("b.derp", {3'b0, derp_b}, int'(m.derp));
      chkx("b.err", {3'b0, err_b}, int'(m.err));
      chkx("b.dir", {2'b0, dir_b}, m.dir);
      chkx("b.cnt", {2'b0, cnt_b}, m.cnt_b);
    end
  end

  // Drive one sample, then return 1 time unit after the edge that takes it.
  task automatic apply(input bit r, input bit e, input bit c, input logic [7:0] b);
    rst_n = r; en = e; clr_n = c; bus = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles with the bus at the left boundary.
    apply(0, 1, 1, 8'h08);
    apply(0, 1, 1, 8'h08);
    chk("rst.izq", int'(izq_a), 1);
    chk("rst.izqp", int'(izqp_a), 1);
    chk("rst.dir", int'(dir_a), 0);
    chk("rst.cnt", int'(cnt_a), 0);
    chk("rst.err", int'(err_a), 1);
    apply(1, 1, 1, 8'h08);
    chk("first.izq", int'(izq_a), 0);
    chk("first.izqp", int'(izqp_a), 0);
    chk("first.dir", int'(dir_a), 0);
    apply(1, 1, 1, 8'h01);
    chk("s01.dir", int'(dir_a), 1);
    chk("s01.derp", int'(derp_a), 0);
    chk("s01.cnt", int'(cnt_a), 0);
    apply(1, 1, 1, 8'h02);
    chk("s02.dir", int'(dir_a), 2);
    apply(1, 1, 1, 8'h04);
    apply(1, 1, 1, 8'h08);
    chk("s08.izqp", int'(izqp_a), 0);
    chk("s08.dir", int'(dir_a), 1);
    chk("s08.cnt", int'(cnt_a), 1);
    apply(1, 1, 1, 8'h04);
    chk("s04.izq", int'(izq_a), 1);
    chk("s04.izqp", int'(izqp_a), 1);
    apply(1, 1, 1, 8'h02);
    apply(1, 1, 1, 8'h01);
    chk("r01.derp", int'(derp_a), 0);
    chk("r01.der", int'(der_a), 0);
    chk("r01.dir", int'(dir_a), 2);
    chk("r01.cnt", int'(cnt_a), 2);
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 1, 8'h01);
      chk("hold.derp", int'(derp_a), 1);
      chk("hold.cnt", int'(cnt_a), 2);
    end
    // Non-one-hot sample, then recovery from idle.
    apply(1, 1, 1, 8'h0C);
    chk("bad.err", int'(err_a), 0);
    chk("bad.dir", int'(dir_a), 0);
    chk("bad.der", int'(der_a), 1);
    chk("bad.izq", int'(izq_a), 1);
    apply(1, 1, 1, 8'h04);
    chk("rec.err", int'(err_a), 1);
    chk("rec.dir", int'(dir_a), 0);
    apply(1, 1, 1, 8'h02);
    chk("rec2.dir", int'(dir_a), 1);
    chk("rec2.cnt", int'(cnt_a), 2);
    // Bounce between the boundaries: four more bounces.
    apply(1, 1, 1, 8'h01);
    apply(1, 1, 1, 8'h08);
    apply(1, 1, 1, 8'h01);
    apply(1, 1, 1, 8'h08);
    chk("sat.a", int'(cnt_a), 6);
    chk("sat.b", int'(cnt_b), 3);
    // Clear coincident with a bounce.
    apply(1, 1, 0, 8'h01);
    chk("clr.a", int'(cnt_a), 0);
    chk("clr.b", int'(cnt_b), 0);
    chk("clr.dir", int'(dir_a), 2);
    apply(1, 1, 1, 8'h08);
    chk("post.cnt", int'(cnt_a), 1);
    // Disabled while the bus changes.
    apply(1, 0, 1, 8'h02);
    chk("dis.izqp", int'(izqp_a), 1);
    chk("dis.izq", int'(izq_a), 0);
    apply(1, 0, 1, 8'h04);
    apply(1, 0, 1, 8'h0C);
    apply(1, 0, 1, 8'h00);
    chk("dis.dir", int'(dir_a), 1);
    chk("dis.cnt", int'(cnt_a), 1);
    chk("dis.err", int'(err_a), 1);
    apply(1, 1, 1, 8'h04);
    chk("en.izq", int'(izq_a), 1);
    chk("en.dir", int'(dir_a), 1);
    apply(1, 1, 1, 8'h02);
    // Reset mid-motion overrides enable.
    apply(0, 1, 1, 8'h01);
    chk("mrst.dir", int'(dir_a), 0);
    chk("mrst.cnt", int'(cnt_a), 0);
    chk("mrst.der", int'(der_a), 1);
    apply(1, 1, 1, 8'h01);
    chk("after.derp", int'(derp_a), 0);
    chk("after.dir", int'(dir_a), 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
